// File: rtl/spi_card_responder_if.sv
// spi_card_responder_if: SPI pins, received byte/command outputs and TX FIFO port of the card responder
interface spi_card_responder_if #(parameter int TX_DEPTH = 4);
  localparam int LW = $clog2(TX_DEPTH + 1);
  logic spi_clock, spi_dataout, card_cs_n, spi_datain;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0] cmd_crc;
  logic cmd_valid;
  logic [7:0] tx_byte;
  logic tx_write, tx_full, tx_overflow;
  logic [LW-1:0] tx_level;
  modport slave (
    input spi_clock, spi_dataout, card_cs_n, tx_byte, tx_write,
    output spi_datain, rx_byte, rx_valid, cmd_index, cmd_arg, cmd_crc, cmd_valid, tx_full, tx_level, tx_overflow
  );
  modport master (
    output spi_clock, spi_dataout, card_cs_n, tx_byte, tx_write,
    input spi_datain, rx_byte, rx_valid, cmd_index, cmd_arg, cmd_crc, cmd_valid, tx_full, tx_level, tx_overflow
  );
endinterface

// File: rtl/spi_card_responder.sv
// spi_card_responder: oversampled SPI mode-0 card-side slave with SD command framer and response TX FIFO
module spi_card_responder #(
  parameter int TX_DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input logic clock,
  input logic reset,
  spi_card_responder_if.slave bus
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int LW = $clog2(TX_DEPTH + 1);
  typedef enum logic {HUNT, COLLECT} state_t;
  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
  logic sck_d, cs_d, sel, rise, fall, cs_fall, load, done;
  logic [3:0] bit_cnt;
  logic [7:0] rx_shift, rx_byte, load_byte;
  logic [6:0] tx_shift;
  logic rx_valid, miso;
  logic [7:0] mem [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level, level_n;
  logic full, overflow, do_pop, do_push, empty;
  state_t state, state_n;
  logic [2:0] byte_cnt;
  logic [5:0] idx_s, cmd_index;
  logic [31:0] arg_s, cmd_arg;
  logic [6:0] cmd_crc;
  logic cmd_valid, hunt_hit, coll, last;
  assign sel = ~cs_q[SYNC_STAGES-1];
  assign rise = sel & sck_q[SYNC_STAGES-1] & ~sck_d;
  assign fall = sel & ~sck_q[SYNC_STAGES-1] & sck_d;
  assign cs_fall = sel & cs_d;
  assign load = cs_fall | (fall & bit_cnt == 4'd8);
  assign empty = level == '0;
  assign load_byte = empty ? IDLE_BYTE : mem[rptr];
  assign do_pop = load & ~empty;
  assign do_push = bus.tx_write & (level != LW'(TX_DEPTH) | do_pop);
  assign level_n = (do_push & ~do_pop) ? level + 1'b1 : (do_pop & ~do_push) ? level - 1'b1 : level;
  always_ff @(posedge clock) begin
    if (!reset) begin
      sck_q <= '0;
      mosi_q <= '1;
      cs_q <= '1;
      sck_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.spi_clock};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.spi_dataout};
      cs_q <= {cs_q[SYNC_STAGES-2:0], bus.card_cs_n};
      sck_d <= sck_q[SYNC_STAGES-1];
      cs_d <= cs_q[SYNC_STAGES-1];
    end
  end
  // done marks the eighth rising edge; the byte is published one clock later
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '1;
      miso <= 1'b1;
      done <= 1'b0;
      rx_byte <= 8'hFF;
      rx_valid <= 1'b0;
    end else begin
      done <= rise & bit_cnt == 4'd7;
      rx_valid <= done;
      if (done) rx_byte <= rx_shift;
      if (!sel) begin
        bit_cnt <= '0;
        miso <= 1'b1;
      end else if (load) begin
        bit_cnt <= '0;
        tx_shift <= load_byte[6:0];
        miso <= load_byte[7];
      end else if (rise) begin
        bit_cnt <= bit_cnt + 4'd1;
        rx_shift <= {rx_shift[6:0], mosi_q[SYNC_STAGES-1]};
      end else if (fall) begin
        tx_shift <= {tx_shift[5:0], 1'b1};
        miso <= tx_shift[6];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level <= level_n;
      full <= level_n == LW'(TX_DEPTH);
      if (bus.tx_write & ~do_push) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clock) if (do_push) mem[wptr] <= bus.tx_byte;
  assign hunt_hit = sel & rx_valid & state == HUNT & rx_byte[7:6] == 2'b01;
  assign coll = sel & rx_valid & state == COLLECT;
  assign last = coll & byte_cnt == 3'd5;
  always_ff @(posedge clock) state <= !reset ? HUNT : state_n;
  always_comb state_n = (!sel || last) ? HUNT : hunt_hit ? COLLECT : state;
  always_ff @(posedge clock) begin
    if (!reset) begin
      byte_cnt <= '0;
      idx_s <= '0;
      arg_s <= '0;
      cmd_index <= '0;
      cmd_arg <= '0;
      cmd_crc <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= last & rx_byte[0];
      if (hunt_hit) begin
        idx_s <= rx_byte[5:0];
        byte_cnt <= 3'd1;
      end else if (coll & ~last) begin
        arg_s <= {arg_s[23:0], rx_byte};
        byte_cnt <= byte_cnt + 3'd1;
      end
      if (last & rx_byte[0]) begin
        cmd_index <= idx_s;
        cmd_arg <= arg_s;
        cmd_crc <= rx_byte[7:1];
      end
    end
  end
  assign bus.spi_datain = miso;
  assign bus.rx_byte = rx_byte;
  assign bus.rx_valid = rx_valid;
  assign bus.cmd_index = cmd_index;
  assign bus.cmd_arg = cmd_arg;
  assign bus.cmd_crc = cmd_crc;
  assign bus.cmd_valid = cmd_valid;
  assign bus.tx_full = full;
  assign bus.tx_level = level;
  assign bus.tx_overflow = overflow;
endmodule
